// File: rtl/clkdiv_sched.sv
// clkdiv_sched: two-requester ratio scheduler driving a clock-enable divider.
// Define CLKDIV_SCHED_IMMEDIATE_EN to apply ratios on the handshake edge.
module clkdiv_sched #(
  parameter int WIDE  = 8,
  parameter int DEF_N = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [WIDE-1:0] req0_div,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [WIDE-1:0] req1_div,
  output logic            req1_ready,
  output logic            tick,
  output logic            div_out,
  output logic [WIDE-1:0] cur_div,
  output logic            busy,
  output logic            err
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [WIDE-1:0] DEF = WIDE'(DEF_N);
  localparam logic [WIDE-1:0] ONE = WIDE'(1);

  state_t          state_q;
  state_t          state_d;
  logic [WIDE-1:0] cnt_q;
  logic [WIDE-1:0] cur_q;
  logic            ptr_q;
  logic            tick_q;
  logic            dout_q;
  logic            err_q;

  logic            run;
  logic            gnt0;
  logic            gnt1;
  logic            hs;
  logic            hs_zero;
  logic [WIDE-1:0] hs_div;
  logic            wrap;

  always_comb begin
    run     = (state_q == RUN);
    gnt0    = run & ~rst & req0_valid & (~req1_valid | ~ptr_q);
    gnt1    = run & ~rst & req1_valid & (~req0_valid | ptr_q);
    hs      = gnt0 | gnt1;
    hs_div  = gnt0 ? req0_div : req1_div;
    hs_zero = (hs_div == '0);
    wrap    = (cnt_q == cur_q - ONE);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
`ifndef CLKDIV_SCHED_IMMEDIATE_EN
        if (hs && !hs_zero) state_d = PEND;
`endif
      end
      PEND: begin
        if (wrap) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

`ifndef CLKDIV_SCHED_IMMEDIATE_EN
  logic [WIDE-1:0] pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= DEF;
    end else if (hs && !hs_zero) begin
      pend_q <= hs_div;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      cur_q   <= DEF;
      ptr_q   <= 1'b0;
      tick_q  <= 1'b0;
      dout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= wrap;
      dout_q  <= (cnt_q >= (cur_q >> 1));
      err_q   <= hs & hs_zero;
      if (hs) ptr_q <= ~ptr_q;
      cnt_q   <= wrap ? '0 : cnt_q + ONE;
`ifdef CLKDIV_SCHED_IMMEDIATE_EN
      // truncate the running period and restart at the new ratio
      if (hs && !hs_zero) begin
        cur_q <= hs_div;
        cnt_q <= '0;
      end
`else
      if (state_q == PEND && wrap) cur_q <= pend_q;
`endif
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign tick       = tick_q;
  assign div_out    = dout_q;
  assign cur_div    = cur_q;
  assign err        = err_q;
`ifdef CLKDIV_SCHED_IMMEDIATE_EN
  assign busy       = 1'b0;
`else
  assign busy       = (state_q == PEND);
`endif

endmodule
